// File: rtl/demux_reg_88.sv
// demux_reg_88: valid/ready write port that routes one byte into one of eight
// held output registers (a..h). FILL sequences one byte into all eight, one per cycle.
// Optional feature macro: DEMUX_STROBE_EN adds stb[7:0], a one-cycle update pulse per register.
module demux_reg_88 #(
  parameter logic [7:0] RESET_VAL  = 8'h00,
  parameter logic [2:0] FILL_START = 3'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] sel,
  input  logic [1:0] cmd,
  input  logic [7:0] d,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d_o,
  output logic [7:0] e,
  output logic [7:0] f,
  output logic [7:0] g,
  output logic [7:0] h,
  output logic [7:0] written,
`ifdef DEMUX_STROBE_EN
  output logic [7:0] stb,
`endif
  output logic       busy
);

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned IW   = 3;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_FILL  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;

  typedef enum logic {ST_IDLE, ST_FILL} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] written_q, written_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   fill_q, fill_d;

  // Next-state decode: IDLE accepts one command per edge, FILL walks the index
  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    written_d = written_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          case (cmd)
            CMD_WRITE: begin
              regs_d[sel]    = d;
              written_d[sel] = 1'b1;
            end
            CMD_FILL: begin
              fill_d  = d;
              idx_d   = FILL_START;
              cnt_d   = IW'(0);
              state_d = ST_FILL;
            end
            CMD_CLEAR: begin
              for (int i = 0; i < NREG; i++) regs_d[i] = RESET_VAL;
              written_d = '0;
            end
            default: ;
          endcase
        end
      end
      ST_FILL: begin
        regs_d[idx_q]    = fill_q;
        written_d[idx_q] = 1'b1;
        idx_d            = idx_q + IW'(1);
        cnt_d            = cnt_q + IW'(1);
        if (cnt_q == IW'(NREG - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any FILL in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL;
      written_q <= '0;
      idx_q     <= FILL_START;
      cnt_q     <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      written_q <= written_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
    end
  end

`ifdef DEMUX_STROBE_EN
  logic [NREG-1:0] stb_q, stb_d;

  // One-hot of the register updated on this edge (WRITE or FILL step, never CLEAR)
  always_comb begin
    stb_d = '0;
    if (state_q == ST_FILL) stb_d[idx_q] = 1'b1;
    else if (wr_valid && (cmd == CMD_WRITE)) stb_d[sel] = 1'b1;
  end

  // Strobe register: pulse appears the cycle the new value becomes visible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stb_q <= '0;
    else          stb_q <= stb_d;
  end

  assign stb = stb_q;
`endif

  assign wr_ready = (state_q == ST_IDLE) && reset_n;
  assign busy     = (state_q == ST_FILL);
  assign written  = written_q;
  assign a        = regs_q[0];
  assign b        = regs_q[1];
  assign c        = regs_q[2];
  assign d_o      = regs_q[3];
  assign e        = regs_q[4];
  assign f        = regs_q[5];
  assign g        = regs_q[6];
  assign h        = regs_q[7];

endmodule
